// File: rtl/dip_pkg.sv
// Shared sizes and the per-button auto-repeat state encoding for the DIP/button conditioner.
package dip_pkg;
  localparam int NUM_BTN  = 5;
  localparam int SW_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;
endpackage

// File: rtl/debounce_bit.sv
// Frame-strobed candidate/counter debouncer: the level follows the sampled word once it has
// been seen DEB_FRAMES strobes in a row, with a one-cycle pulse when the level actually changes.
module debounce_bit #(
  parameter int DEB_FRAMES = 4,
  parameter int WIDTH      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_strobe,
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH-1:0] o_level,
  output logic             o_changed
);
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_FRAMES);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (i_sample == cand_q) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end else begin
      cand_d = i_sample;
      cnt_d  = CW'(1);
    end
  end

  // Level and pulse register together so they become visible in the cycle after the strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cand_q    <= '0;
      cnt_q     <= '0;
      o_level   <= '0;
      o_changed <= 1'b0;
    end else begin
      o_changed <= 1'b0;
      if (i_strobe) begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
        if (cnt_d == CNT_MAX && cand_d != o_level) begin
          o_level   <= cand_d;
          o_changed <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dip_input_conditioner.sv
// Debounces the frame-rate switch word and push buttons; derives press/release edges and
// per-button auto-repeat pulses from the debounced button levels.
module dip_input_conditioner
  import dip_pkg::*;
#(
  parameter int                 SW_FRAMES     = 4,
  parameter int                 BTN_FRAMES    = 3,
  parameter int                 HOLD_FRAMES   = 200,
  parameter int                 REPEAT_FRAMES = 40,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK   = 5'h1F
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_frameStrobe,
  input  logic [SW_WIDTH-1:0] i_data,
  input  logic [NUM_BTN-1:0]  i_pushB,
  output logic [SW_WIDTH-1:0] o_switches,
  output logic                o_swChanged,
  output logic [NUM_BTN-1:0]  o_btnLevel,
  output logic [NUM_BTN-1:0]  o_btnPress,
  output logic [NUM_BTN-1:0]  o_btnRelease,
  output logic [NUM_BTN-1:0]  o_btnRepeat
);
  localparam int HW     = $clog2(HOLD_FRAMES + 1);
  localparam int RELOAD = (REPEAT_FRAMES >= HOLD_FRAMES) ? 0 : HOLD_FRAMES - REPEAT_FRAMES;
  localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0] RELOAD_V = HW'(RELOAD);

  logic [NUM_BTN-1:0] btn_chg;
  logic [NUM_BTN-1:0] rpt_q;

  debounce_bit #(.DEB_FRAMES(SW_FRAMES), .WIDTH(SW_WIDTH)) u_sw_deb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_strobe (i_frameStrobe),
    .i_sample (i_data),
    .o_level  (o_switches),
    .o_changed(o_swChanged)
  );

  assign o_btnPress   = btn_chg & o_btnLevel;
  assign o_btnRelease = btn_chg & ~o_btnLevel;
  // A repeat fired on the strobe that also releases the button is dropped here
  assign o_btnRepeat  = rpt_q & o_btnLevel;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_inc;
    logic          fire, rpt_r;

    debounce_bit #(.DEB_FRAMES(BTN_FRAMES), .WIDTH(1)) u_btn_deb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_strobe (i_frameStrobe),
      .i_sample (i_pushB[g]),
      .o_level  (o_btnLevel[g]),
      .o_changed(btn_chg[g])
    );

    assign hold_inc = hold_q + HW'(1);
    assign fire     = REPEAT_MASK[g] && i_frameStrobe && o_btnLevel[g] && (hold_inc >= HOLD_V);
    assign rpt_q[g] = rpt_r;

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (o_btnLevel[g]) state_d = HELD;
        HELD:    if (!o_btnLevel[g]) state_d = IDLE;
                 else if (fire) state_d = REPEAT;
        REPEAT:  if (!o_btnLevel[g]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Hold counter only runs while the debounced level is high; masked-off buttons saturate at HOLD
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_q <= IDLE;
        hold_q  <= '0;
        rpt_r   <= 1'b0;
      end else begin
        state_q <= state_d;
        rpt_r   <= fire;
        if (!o_btnLevel[g]) hold_q <= '0;
        else if (i_frameStrobe) begin
          if (fire) hold_q <= RELOAD_V;
          else if (hold_q != HOLD_V) hold_q <= hold_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_dip_input_conditioner.sv
// Bench for dip_input_conditioner: constant vector table, directed multi-frame sequences and a
// random phase, all compared every cycle against a frame-history reference model.
module tb_dip_input_conditioner;
  localparam int SW   = 4;
  localparam int BTN  = 3;
  localparam int HOLD = 200;
  localparam int REP  = 40;
  localparam logic [4:0] MASK = 5'h0F;

  logic        i_clk = 1'b0;
  logic        i_rst, i_frameStrobe;
  logic [15:0] i_data;
  logic [4:0]  i_pushB;
  logic [15:0] o_switches;
  logic        o_swChanged;
  logic [4:0]  o_btnLevel, o_btnPress, o_btnRelease, o_btnRepeat;

  dip_input_conditioner #(
    .SW_FRAMES(SW), .BTN_FRAMES(BTN), .HOLD_FRAMES(HOLD),
    .REPEAT_FRAMES(REP), .REPEAT_MASK(MASK)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frameStrobe(i_frameStrobe), .i_data(i_data),
    .i_pushB(i_pushB), .o_switches(o_switches), .o_swChanged(o_swChanged),
    .o_btnLevel(o_btnLevel), .o_btnPress(o_btnPress), .o_btnRelease(o_btnRelease),
    .o_btnRepeat(o_btnRepeat)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: remembers the most recent sampled frames and how many strobes each
  // button has been held, and derives outputs from those directly.
  logic [15:0] sw_q[$];
  logic [4:0]  bq[$];
  int          hk[5];
  logic [15:0] m_sw;
  logic        m_chg;
  logic [4:0]  m_lvl, m_press, m_rel, m_rpt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic s, input logic [15:0] d, input logic [4:0] p);
    logic [4:0] prev_lvl;
    logic       eq, pend;
    prev_lvl = m_lvl;
    m_chg = 1'b0; m_press = '0; m_rel = '0; m_rpt = '0;
    if (r) begin
      m_sw = '0; m_lvl = '0;
      for (int n = 0; n < 5; n++) hk[n] = 0;
      sw_q.delete(); bq.delete();
    end else begin
      if (s) begin
        sw_q.push_back(d); if (sw_q.size() > SW) void'(sw_q.pop_front());
        bq.push_back(p);   if (bq.size() > BTN) void'(bq.pop_front());
        if (sw_q.size() == SW) begin
          eq = 1'b1;
          foreach (sw_q[j]) if (sw_q[j] != sw_q[0]) eq = 1'b0;
          if (eq && sw_q[0] != m_sw) begin m_sw = sw_q[0]; m_chg = 1'b1; end
        end
        if (bq.size() == BTN) begin
          for (int n = 0; n < 5; n++) begin
            eq = 1'b1;
            foreach (bq[j]) if (bq[j][n] != bq[0][n]) eq = 1'b0;
            if (eq && bq[0][n] != m_lvl[n]) begin
              m_lvl[n] = bq[0][n];
              if (bq[0][n]) m_press[n] = 1'b1; else m_rel[n] = 1'b1;
            end
          end
        end
      end
      for (int n = 0; n < 5; n++) begin
        pend = 1'b0;
        if (s && prev_lvl[n]) begin
          hk[n]++;
          if (MASK[n] && hk[n] >= HOLD && ((hk[n] - HOLD) % REP) == 0) pend = 1'b1;
        end
        if (!m_lvl[n]) hk[n] = 0;
        m_rpt[n] = pend && m_lvl[n];
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [15:0] d, input logic [4:0] p);
    i_rst = r; i_frameStrobe = s; i_data = d; i_pushB = p;
    @(posedge i_clk);
    model(r, s, d, p);
    #1;
    check("m_switches", o_switches,   m_sw);
    check("m_swChanged", o_swChanged, m_chg);
    check("m_btnLevel", o_btnLevel,   m_lvl);
    check("m_btnPress", o_btnPress,   m_press);
    check("m_btnRelease", o_btnRelease, m_rel);
    check("m_btnRepeat", o_btnRepeat, m_rpt);
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic [15:0] d;
    logic [4:0]  p;
    logic [15:0] esw;
    logic        echg;
    logic [4:0]  elvl;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic [15:0] d, logic [4:0] p,
                              logic [15:0] esw, logic echg, logic [4:0] elvl);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.p = p; v.esw = esw; v.echg = echg; v.elvl = elvl;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int press_cnt, rel_cnt, rpt_cnt, rpt1, rpt4, press_i, first_k, second_k, dsel, tog;
    logic [4:0]  press_v, pr;
    logic [15:0] pool[3];

    i_rst = 1'b1; i_frameStrobe = 1'b0; i_data = '0; i_pushB = '0;
    m_sw = '0; m_chg = 1'b0; m_lvl = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    for (int n = 0; n < 5; n++) hk[n] = 0;

    // Reset with strobes running, then switch filter and alternating no-change words
    tbl[0]  = mk(1, 1, 16'hFFFF, 5'h1F, 16'h0000, 0, 5'h00);
    tbl[1]  = mk(1, 1, 16'h1234, 5'h1F, 16'h0000, 0, 5'h00);
    tbl[2]  = mk(0, 1, 16'hA5A5, 5'h00, 16'h0000, 0, 5'h00);
    tbl[3]  = mk(0, 1, 16'hA5A5, 5'h00, 16'h0000, 0, 5'h00);
    tbl[4]  = mk(0, 1, 16'hA5A5, 5'h00, 16'h0000, 0, 5'h00);
    tbl[5]  = mk(0, 1, 16'hA5A5, 5'h00, 16'hA5A5, 1, 5'h00);
    tbl[6]  = mk(0, 0, 16'hA5A5, 5'h00, 16'hA5A5, 0, 5'h00);
    tbl[7]  = mk(0, 1, 16'h00FF, 5'h00, 16'hA5A5, 0, 5'h00);
    tbl[8]  = mk(0, 1, 16'h00FF, 5'h00, 16'hA5A5, 0, 5'h00);
    tbl[9]  = mk(0, 1, 16'h00FF, 5'h00, 16'hA5A5, 0, 5'h00);
    tbl[10] = mk(0, 1, 16'h00FF, 5'h00, 16'h00FF, 1, 5'h00);
    tbl[11] = mk(0, 1, 16'h00FE, 5'h00, 16'h00FF, 0, 5'h00);
    tbl[12] = mk(0, 1, 16'h00FF, 5'h00, 16'h00FF, 0, 5'h00);
    tbl[13] = mk(0, 1, 16'h00FE, 5'h00, 16'h00FF, 0, 5'h00);
    tbl[14] = mk(0, 1, 16'h00FF, 5'h00, 16'h00FF, 0, 5'h00);
    tbl[15] = mk(0, 0, 16'h00FF, 5'h00, 16'h00FF, 0, 5'h00);

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].p);
      check($sformatf("tbl_sw[%0d]", i),  o_switches,  tbl[i].esw);
      check($sformatf("tbl_chg[%0d]", i), o_swChanged, tbl[i].echg);
      check($sformatf("tbl_lvl[%0d]", i), o_btnLevel,  tbl[i].elvl);
    end

    // Bouncing press on button 2
    press_cnt = 0; rel_cnt = 0; press_v = '0;
    foreach (pool[j]) pool[j] = '0;
    pool[0] = 16'h0001; pool[1] = 16'h0000; pool[2] = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      logic [4:0] pv;
      pv = (i == 1) ? 5'b00000 : 5'b00100;
      cyc(0, 1, 16'h00FF, pv);
      if (o_btnPress != 0) begin press_cnt++; press_v = o_btnPress; end
      if (o_btnRelease != 0) rel_cnt++;
      if (i == 4) check("bounce_press_5th", o_btnPress, 5'b00100);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 16'h00FF, 5'b00100);
      if (o_btnPress != 0) press_cnt++;
      if (o_btnRelease != 0) rel_cnt++;
    end
    check("bounce_press_count", press_cnt, 1);
    check("bounce_press_vec", press_v, 5'b00100);
    check("bounce_level2", o_btnLevel[2], 1'b1);
    check("bounce_no_release", rel_cnt, 0);
    rel_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 16'h00FF, 5'b00000);
      if (o_btnRelease == 5'b00100) rel_cnt++;
    end
    check("bounce_release", rel_cnt, 1);

    // Auto-repeat on button 0 held 300 frames after the press
    press_i = -1; rpt_cnt = 0; first_k = -1; second_k = -1;
    for (int i = 0; i < 303; i++) begin
      cyc(0, 1, 16'h00FF, 5'b00001);
      if (o_btnPress[0]) press_i = i;
      if (o_btnRepeat[0]) begin
        rpt_cnt++;
        if (rpt_cnt == 1) first_k = i - press_i;
        if (rpt_cnt == 2) second_k = i - press_i;
      end
    end
    check("hold_press_idx", press_i, 2);
    check("hold_first_rpt", first_k, 200);
    check("hold_second_rpt", second_k, 240);
    check("hold_rpt_count", rpt_cnt, 3);
    rel_cnt = 0; rpt_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1, 16'h00FF, 5'b00000);
      if (o_btnRelease[0]) rel_cnt++;
      if (o_btnRepeat[0]) rpt_cnt++;
    end
    check("hold_release", rel_cnt, 1);
    check("hold_no_rpt_after_rel", rpt_cnt, 0);

    // Buttons 1 and 4 together; only button 1 is repeat-enabled
    press_cnt = 0; press_v = '0; rpt1 = 0; rpt4 = 0;
    for (int i = 0; i < 260; i++) begin
      cyc(0, 1, 16'h00FF, 5'b10010);
      if (o_btnPress != 0) begin press_cnt++; press_v = o_btnPress; end
      if (o_btnRepeat[1]) rpt1++;
      if (o_btnRepeat[4]) rpt4++;
    end
    check("simul_press_cycles", press_cnt, 1);
    check("simul_press_vec", press_v, 5'b10010);
    check("simul_rpt1", rpt1, 2);
    check("simul_rpt4", rpt4, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h00FF, 5'b00000);

    // Reset 150 frames into a hold of button 3
    for (int i = 0; i < 153; i++) cyc(0, 1, 16'h00FF, 5'b01000);
    check("midrst_level_before", o_btnLevel[3], 1'b1);
    cyc(1, 1, 16'h00FF, 5'b01000);
    check("midrst_level", o_btnLevel, 5'b00000);
    check("midrst_switches", o_switches, 16'h0000);
    check("midrst_no_release", o_btnRelease, 5'b00000);
    rel_cnt = 0; rpt_cnt = 0; press_i = -1;
    for (int i = 0; i < 70; i++) begin
      cyc(0, 1, 16'h00FF, 5'b01000);
      if (o_btnPress[3]) press_i = i;
      if (o_btnRelease != 0) rel_cnt++;
      if (o_btnRepeat != 0) rpt_cnt++;
    end
    check("midrst_repress_idx", press_i, 2);
    check("midrst_no_rel_after", rel_cnt, 0);
    check("midrst_no_rpt", rpt_cnt, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h00FF, 5'b00000);

    // Random frames: fast-toggling buttons first, then long holds that reach auto-repeat
    pool[0] = 16'h1234; pool[1] = 16'hBEEF; pool[2] = 16'h0F0F;
    dsel = 0; pr = '0;
    for (int i = 0; i < 3000; i++) begin
      logic r, s;
      tog = (i < 1500) ? 15 : 300;
      s = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0) dsel = $urandom_range(0, 2);
      if ($urandom_range(0, tog) == 0) pr = pr ^ 5'(1 << $urandom_range(0, 4));
      r = ($urandom_range(0, 599) == 0);
      cyc(r, s, pool[dsel], pr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
